l2_vec_arbiter: RTL and testbench
=================================

L2_VEC_ARBITER -- requirements
Module: l2_vec_arbiter

Interface
REQ-001 Parameter DW, default 8, input element width (unsigned).
REQ-002 Parameter AW, default 20, accumulator/result width (unsigned).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a0 / a1  input  DW each  element data from requester 0 / requester 1.
REQ-006 valid0 / valid1  input  1 each  element on a0 / a1 is valid.
REQ-007 last0 / last1  input  1 each  element on a0 / a1 is the final element of its vector.
REQ-008 ready0 / ready1  output  1 each  arbiter accepts the element from requester 0 / requester 1 this cycle.
REQ-009 f  output  AW  sum of squares of the completed vector.
REQ-010 valid_out  output  1  f, id_out, len_out and ovf_out are valid; single-cycle pulse; no backpressure.
REQ-011 id_out  output  1  requester (0/1) owning the result.
REQ-012 len_out  output  8  element count of the completed vector; saturates at 255.
REQ-013 ovf_out  output  1  accumulation saturated during this vector.

Function
REQ-014 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: if valid0 or valid1 is high, register grant and go to RUN next cycle; otherwise stay in IDLE; ready0 = ready1 = 0 in IDLE.
REQ-016 Grant rule: one requester valid -> that requester; both valid -> the requester not served last (round robin); after reset requester 0 wins the first tie.
REQ-017 Grant is locked for the whole vector; the other requester receives no ready until DONE has completed.
REQ-018 Entering RUN clears the accumulator, element count and overflow flag.
REQ-019 RUN: ready of granted requester = 1, other = 0; a beat is accepted when valid and ready are both high; cycles with valid low are stalls that change nothing.
REQ-020 Each accepted beat adds a*a (full 2*DW-bit product, zero-extended) to the accumulator and increments the element count.
REQ-021 Accumulator saturates at 2^AW-1 (0xFFFFF at defaults); any beat that would exceed it sets the overflow flag, which stays set until the next RUN entry.
REQ-022 Beat accepted with last high -> DONE on the next edge; no further beats are accepted in that vector.
REQ-023 DONE lasts exactly one cycle: valid_out = 1, f = accumulator, id_out = grant, len_out = count, ovf_out = flag; then IDLE.
REQ-024 Latency: valid_out rises in the cycle immediately after the edge that accepts the last beat; minimum of 2 idle-ready cycles between vectors (DONE, IDLE).
REQ-025 Outside DONE: valid_out = 0; f, id_out, len_out and ovf_out hold their last values (0 after reset).
REQ-026 Single-element vector (valid and last on the first accepted beat) is legal; result = a*a, len_out = 1.

Reset
REQ-027 reset high at a rising edge forces IDLE, ready0 = ready1 = 0, valid_out = 0, f = 0, id_out = 0, len_out = 0, ovf_out = 0, accumulator cleared, round-robin pointer set so requester 0 wins the next tie.
REQ-028 Reset in RUN or DONE abandons the in-flight vector; no valid_out is produced for it.

Structure
REQ-029 Shared package l2_sched_pkg holds the state enum, DW/AW defaults and the 8-bit length width constant.
REQ-030 Square-accumulate datapath is a sub-module sq_acc (inputs: clear, en, a; outputs: acc, ovf), instantiated once; arbitration and FSM are in l2_vec_arbiter.

Verification
REQ-031 req0 sends {3,4} with last on 4 -> one valid_out pulse with f=0x00019, id_out=0, len_out=2, ovf_out=0.
REQ-032 valid0 and valid1 rise in the same cycle with 1-element vectors {2} and {5} -> result f=0x4 id 0, then f=0x19 id 1; ready1 stays 0 until req0's DONE.
REQ-033 req0 sends 17 elements of 0xFF -> after 16 beats accumulator = 0xFE010 (1040400); final f=0xFFFFF, ovf_out=1, len_out=17.
REQ-034 req0 inserts valid-low stalls between elements {1,1,1} -> f=0x3, len_out=3; stalls leave the accumulator unchanged.
REQ-035 req0 sends two back-to-back vectors while req1 holds a pending vector -> order served: req0, req1, req0.
REQ-036 reset asserted in RUN after 2 accepted beats -> next cycle ready0 = ready1 = 0, no valid_out; a following vector {6} yields f=0x24, len_out=1.

Source files
------------

// File: rtl/l2_sched_pkg.sv
// Shared types and width defaults for the two-requester sum-of-squares arbiter.
package l2_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 20;
  localparam int LEN_W  = 8;

endpackage

// File: rtl/sq_acc.sv
// Saturating square-accumulate datapath: acc += a*a on each enabled cycle,
// clamping at 2^AW-1 and latching an overflow flag until the next clear.
module sq_acc
  import l2_sched_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic [DW-1:0] a,
  output logic [AW-1:0] acc,
  output logic          ovf
);

  // One guard bit above the wider of the product and the accumulator.
  localparam int SW = ((2 * DW > AW) ? 2 * DW : AW) + 1;
  localparam logic [SW-1:0] ACC_MAX = {{(SW - AW){1'b0}}, {AW{1'b1}}};

  logic [SW-1:0] sq;
  logic [SW-1:0] sum;
  logic          sat;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    sq  = SW'(a) * SW'(a);
    sum = SW'(acc) + sq;
    sat = (sum > ACC_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (sat) begin
        acc <= '1;
        ovf <= 1'b1;
      end else begin
        acc <= sum[AW-1:0];
      end
    end
  end

endmodule

// File: rtl/l2_vec_arbiter.sv
// Round-robin arbiter between two vector streams; each granted vector is
// reduced to a saturating sum of squares and reported in a one-cycle DONE.
module l2_vec_arbiter
  import l2_sched_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    a0,
  input  logic [DW-1:0]    a1,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             last0,
  input  logic             last1,
  output logic             ready0,
  output logic             ready1,
  output logic [AW-1:0]    f,
  output logic             valid_out,
  output logic             id_out,
  output logic [LEN_W-1:0] len_out,
  output logic             ovf_out
);

  state_t            state;
  logic              grant;
  logic              last_served;
  logic [LEN_W-1:0]  count;
  logic [AW-1:0]     f_hold;
  logic              ovf_hold;
  logic [AW-1:0]     acc;
  logic              acc_ovf;

  logic              grant_nxt;
  logic              sel_valid;
  logic              sel_last;
  logic [DW-1:0]     sel_a;
  logic              accept;
  logic              clear;
  logic [LEN_W-1:0]  count_inc;

  always_comb begin
    // A tie goes to whoever was not served last; otherwise the lone requester.
    grant_nxt = (valid0 && valid1) ? ~last_served : valid1;
    sel_valid = grant ? valid1 : valid0;
    sel_last  = grant ? last1  : last0;
    sel_a     = grant ? a1     : a0;
    accept    = sel_valid && (ready0 || ready1);
    clear     = (state == ST_IDLE) && (valid0 || valid1);
    count_inc = (count == '1) ? count : count + 1'b1;
  end

  sq_acc #(
    .DW(DW),
    .AW(AW)
  ) u_sq_acc (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .en   (accept),
    .a    (sel_a),
    .acc  (acc),
    .ovf  (acc_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ready0      <= 1'b0;
      ready1      <= 1'b0;
      grant       <= 1'b0;
      last_served <= 1'b1;
      count       <= '0;
      valid_out   <= 1'b0;
      id_out      <= 1'b0;
      len_out     <= '0;
      f_hold      <= '0;
      ovf_hold    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid_out <= 1'b0;
          if (valid0 || valid1) begin
            grant       <= grant_nxt;
            last_served <= grant_nxt;
            count       <= '0;
            ready0      <= ~grant_nxt;
            ready1      <= grant_nxt;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            count <= count_inc;
            if (sel_last) begin
              ready0    <= 1'b0;
              ready1    <= 1'b0;
              valid_out <= 1'b1;
              id_out    <= grant;
              len_out   <= count_inc;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Capture the result so it survives the next vector's clear.
          valid_out <= 1'b0;
          f_hold    <= acc;
          ovf_hold  <= acc_ovf;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign f       = valid_out ? acc     : f_hold;
  assign ovf_out = valid_out ? acc_ovf : ovf_hold;

endmodule

// File: tb/tb_l2_vec_arbiter.sv
// Scoreboard bench for l2_vec_arbiter: directed vectors push hand-computed
// results, a negedge monitor pops and compares on every valid_out pulse.
module tb_l2_vec_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a0, a1;
  logic        valid0, valid1, last0, last1;
  logic        ready0, ready1;
  logic [19:0] f;
  logic        valid_out, id_out, ovf_out;
  logic [7:0]  len_out;

  typedef struct packed {
    logic [19:0] f;
    logic        id;
    logic [7:0]  len;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  l2_vec_arbiter #(.DW(8), .AW(20)) dut (
    .clk      (clk),
    .reset    (reset),
    .a0       (a0),
    .a1       (a1),
    .valid0   (valid0),
    .valid1   (valid1),
    .last0    (last0),
    .last1    (last1),
    .ready0   (ready0),
    .ready1   (ready1),
    .f        (f),
    .valid_out(valid_out),
    .id_out   (id_out),
    .len_out  (len_out),
    .ovf_out  (ovf_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got valid_out=1 id=%0d f=0x%0h expected no result at %0t",
                 id_out, f, $time);
      end else begin
        mon_e = sb.pop_front();
        check("res_f",   32'(f),       32'(mon_e.f));
        check("res_id",  32'(id_out),  32'(mon_e.id));
        check("res_len", 32'(len_out), 32'(mon_e.len));
        check("res_ovf", 32'(ovf_out), 32'(mon_e.ovf));
      end
    end
  end

  task automatic set_req(input bit r, input logic v, input logic [7:0] d, input logic l);
    if (r) begin
      valid1 = v; a1 = d; last1 = l;
    end else begin
      valid0 = v; a0 = d; last0 = l;
    end
  endtask

  // Called just after a rising edge; returns just after the edge accepting the last beat.
  task automatic send(input bit r, input logic [7:0] d[$], input int stall);
    for (int i = 0; i < d.size(); i++) begin
      int t = 0;
      set_req(r, 1'b1, d[i], i == d.size() - 1);
      do begin
        @(negedge clk);
        t++;
      end while (!(r ? ready1 : ready0) && t < 2000);
      if (!(r ? ready1 : ready0)) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout: got no ready on req%0d expected ready within 2000 cycles", r);
        set_req(r, 1'b0, 8'h00, 1'b0);
        return;
      end
      @(posedge clk);
      #1;
      set_req(r, 1'b0, 8'h00, 1'b0);
      if (i != d.size() - 1) begin
        repeat (stall) @(posedge clk);
        if (stall > 0) #1;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [19:0] ef, input logic eid, input logic [7:0] el,
                              input logic eo);
    exp_t e;
    e.f = ef; e.id = eid; e.len = el; e.ovf = eo;
    return e;
  endfunction

  initial begin
    logic [7:0] v[$];
    logic [7:0] w[$];
    logic [7:0] u[$];
    int seen;
    int t;

    reset = 1'b1;
    set_req(1'b0, 1'b0, 8'h00, 1'b0);
    set_req(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0",    32'(ready0),    32'd0);
    check("rst_ready1",    32'(ready1),    32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_f",         32'(f),         32'd0);
    check("rst_id",        32'(id_out),    32'd0);
    check("rst_len",       32'(len_out),   32'd0);
    check("rst_ovf",       32'(ovf_out),   32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous request right after reset: requester 0 wins the tie.
    sb.push_back(mk(20'h00004, 1'b0, 8'd1, 1'b0));
    sb.push_back(mk(20'h00019, 1'b1, 8'd1, 1'b0));
    fork
      begin v = {8'd2}; send(1'b0, v, 0); end
      begin w = {8'd5}; send(1'b1, w, 0); end
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("tie_ready1_low", 32'(ready1), 32'd0);
        end
      end
    join
    drain();

    v = {8'd3, 8'd4};
    sb.push_back(mk(20'h00019, 1'b0, 8'd2, 1'b0));
    send(1'b0, v, 0);
    drain();

    v.delete();
    repeat (16) v.push_back(8'hFF);
    sb.push_back(mk(20'hFE010, 1'b0, 8'd16, 1'b0));
    send(1'b0, v, 0);
    drain();

    v.push_back(8'hFF);
    sb.push_back(mk(20'hFFFFF, 1'b0, 8'd17, 1'b1));
    send(1'b0, v, 0);
    drain();

    // Overflow flag must not leak into the next vector.
    v = {8'd1, 8'd1, 8'd1};
    sb.push_back(mk(20'h00003, 1'b0, 8'd3, 1'b0));
    send(1'b0, v, 3);
    drain();

    v.delete();
    repeat (256) v.push_back(8'd1);
    sb.push_back(mk(20'h00100, 1'b1, 8'd255, 1'b0));
    send(1'b1, v, 0);
    drain();

    // req1 becomes pending while req0 streams two back-to-back vectors.
    v = {8'd1, 8'd2};
    u = {8'd4, 8'd4, 8'd4};
    w = {8'd10};
    sb.push_back(mk(20'h00005, 1'b0, 8'd2, 1'b0));
    sb.push_back(mk(20'h00064, 1'b1, 8'd1, 1'b0));
    sb.push_back(mk(20'h00030, 1'b0, 8'd3, 1'b0));
    fork
      begin send(1'b0, v, 0); send(1'b0, u, 0); end
      begin repeat (2) @(posedge clk); #1; send(1'b1, w, 0); end
    join
    drain();

    // Reset in RUN after two accepted beats abandons the vector.
    set_req(1'b0, 1'b1, 8'd7, 1'b0);
    seen = 0;
    t = 0;
    while (seen < 2 && t < 100) begin
      @(negedge clk);
      t++;
      if (ready0) seen++;
    end
    check("rst_run_beats_seen", 32'(seen), 32'd2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_run_ready0",    32'(ready0),    32'd0);
    check("rst_run_ready1",    32'(ready1),    32'd0);
    check("rst_run_valid_out", 32'(valid_out), 32'd0);
    check("rst_run_f",         32'(f),         32'd0);
    check("rst_run_len",       32'(len_out),   32'd0);
    set_req(1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    v = {8'd6};
    sb.push_back(mk(20'h00024, 1'b0, 8'd1, 1'b0));
    send(1'b0, v, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
